// File: rtl/fet_deadtime_sequencer.sv
// Top/bottom FET command sequencer for the step-down stage: non-overlapping gate
// commands with programmable dead time, driver-enable settle and gate fault monitoring.
module fet_deadtime_sequencer #(
    parameter int DT_W      = 6,
    parameter int TO_CYC    = 200,
    parameter int EN_SETTLE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_cfg,
    input  logic            gate_status_top,
    input  logic            gate_status_bot,
    input  logic            fault_clr,
    output logic            enable_fetdriver,
    output logic            fetin_top,
    output logic            fetin_bot,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [2:0]      state_o
);

    localparam int SW = $clog2(EN_SETTLE + 1);
    localparam int TW = $clog2(TO_CYC + 1);

    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(EN_SETTLE);
    localparam logic [TW-1:0]   TO_LIMIT    = TW'(TO_CYC);
    localparam logic [TW-1:0]   TO_LAST     = TW'(TO_CYC - 1);
    localparam logic [DT_W-1:0] DT_ONE      = DT_W'(1);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_TOP   = 2'b01;
    localparam logic [1:0] CODE_BOT   = 2'b10;
    localparam logic [1:0] CODE_SHOOT = 2'b11;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        SETTLE = 3'd1,
        BOT    = 3'd2,
        DT_TOP = 3'd3,
        TOP    = 3'd4,
        DT_BOT = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t          state, state_next;
    logic [SW-1:0]   settle_cnt, settle_next;
    logic [DT_W-1:0] dt_cnt, dt_next;
    logic [TW-1:0]   to_cnt, to_next;
    logic [1:0]      code_next;
    logic [DT_W-1:0] dt_load;
    logic            dt_expired;

    // A programmed dead time of zero still gets one full cycle of both gates off.
    assign dt_load    = (dt_cfg == '0) ? DT_ONE : dt_cfg;
    assign dt_expired = (dt_cnt <= DT_ONE);
    assign state_o    = state;

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        dt_next     = dt_cnt;
        to_next     = to_cnt;
        code_next   = fault_code;

        case (state)
            OFF: begin
                code_next = CODE_NONE;
                if (enable) begin
                    state_next  = SETTLE;
                    settle_next = SETTLE_LOAD;
                end
            end

            // Bottom always conducts first so the bootstrap is charged before top.
            SETTLE: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (settle_cnt <= SW'(1)) begin
                    state_next  = BOT;
                    settle_next = '0;
                end else begin
                    settle_next = settle_cnt - SW'(1);
                end
            end

            BOT: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (gate_status_top) begin
                    state_next = FAULT;
                    code_next  = CODE_SHOOT;
                end else if (pwm_in) begin
                    state_next = DT_TOP;
                    dt_next    = dt_load;
                    to_next    = '0;
                end
            end

            DT_TOP: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (gate_status_bot && (to_cnt >= TO_LAST)) begin
                    state_next = FAULT;
                    code_next  = CODE_BOT;
                    to_next    = TO_LIMIT;
                end else begin
                    if (gate_status_bot) begin
                        to_next = to_cnt + TW'(1);
                    end
                    if (dt_cnt != '0) begin
                        dt_next = dt_cnt - DT_ONE;
                    end
                    if (!pwm_in) begin
                        state_next = BOT;
                    end else if (dt_expired && !gate_status_bot) begin
                        state_next = TOP;
                    end
                end
            end

            TOP: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (gate_status_bot) begin
                    state_next = FAULT;
                    code_next  = CODE_SHOOT;
                end else if (!pwm_in) begin
                    state_next = DT_BOT;
                    dt_next    = dt_load;
                    to_next    = '0;
                end
            end

            DT_BOT: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (gate_status_top && (to_cnt >= TO_LAST)) begin
                    state_next = FAULT;
                    code_next  = CODE_TOP;
                    to_next    = TO_LIMIT;
                end else begin
                    if (gate_status_top) begin
                        to_next = to_cnt + TW'(1);
                    end
                    if (dt_cnt != '0) begin
                        dt_next = dt_cnt - DT_ONE;
                    end
                    if (pwm_in) begin
                        state_next = TOP;
                    end else if (dt_expired && !gate_status_top) begin
                        state_next = BOT;
                    end
                end
            end

            // Only an explicit clear while disabled releases a latched fault.
            FAULT: begin
                if (fault_clr && !enable) begin
                    state_next = OFF;
                    code_next  = CODE_NONE;
                end
            end

            default: begin
                state_next = OFF;
                code_next  = CODE_NONE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= OFF;
            settle_cnt       <= '0;
            dt_cnt           <= '0;
            to_cnt           <= '0;
            enable_fetdriver <= 1'b0;
            fetin_top        <= 1'b0;
            fetin_bot        <= 1'b0;
            fault            <= 1'b0;
            fault_code       <= CODE_NONE;
        end else begin
            state            <= state_next;
            settle_cnt       <= settle_next;
            dt_cnt           <= dt_next;
            to_cnt           <= to_next;
            enable_fetdriver <= (state_next == SETTLE) || (state_next == BOT) ||
                                (state_next == DT_TOP) || (state_next == TOP) ||
                                (state_next == DT_BOT);
            fetin_top        <= (state_next == TOP);
            fetin_bot        <= (state_next == BOT);
            fault            <= (state_next == FAULT);
            fault_code       <= code_next;
        end
    end

endmodule

// File: doc/fet_deadtime_sequencer.md
Name: fet_deadtime_sequencer

Overview:
- Sequences the top and bottom switch FET drivers of the step-down power stage.
- Turns one PWM request into non-overlapping fetin_top/fetin_bot commands with programmable dead time.
- Gates driver enable through a settle period and monitors each driver's gate_status for stuck-gate and shoot-through faults.
- Sits between the loop PWM generator and the two fetdriver instances.

Parameters:
- DT_W, 6: width of dt_cfg, the dead-time cycle count.
- TO_CYC, 200: cycles allowed in a dead-time state for the opposite gate to fall before a fault is raised.
- EN_SETTLE, 16: cycles enable_fetdriver is held high before the first gate command.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  stage enable from the loop controller.
- pwm_in  in  1  1 requests top FET on, 0 requests bottom FET on.
- dt_cfg  in  DT_W  dead time in clk cycles; 0 is treated as 1.
- gate_status_top  in  1  top driver gate-high status.
- gate_status_bot  in  1  bottom driver gate-high status.
- fault_clr  in  1  clears a latched fault, honoured only while enable=0.
- enable_fetdriver  out  1  enable to both drivers.
- fetin_top  out  1  top driver command.
- fetin_bot  out  1  bottom driver command.
- fault  out  1  latched fault flag.
- fault_code  out  2  01 top stuck, 10 bottom stuck, 11 shoot-through, 00 none.
- state_o  out  3  current state, for observation.

Behaviour:
- One clock domain. Reset is synchronous and active-low: when rst_n=0 at a rising clk edge, the block resets.
- Reset values:
  - state=OFF.
  - All outputs 0: enable_fetdriver, fetin_top, fetin_bot, fault, fault_code.
  - Counters cleared.
- Reset asserted mid-operation drops both fetin outputs at that edge.
- State encodings: OFF=0, SETTLE=1, BOT=2, DT_TOP=3, TOP=4, DT_BOT=5, FAULT=6. Code 7 is unreachable and recovers to OFF.
- Outputs are registered and update on the same edge as the state:
  - fetin_top=1 only in TOP.
  - fetin_bot=1 only in BOT.
  - enable_fetdriver=1 in SETTLE, BOT, DT_TOP, TOP and DT_BOT.
- Both fetin outputs are never 1 in the same cycle.
- Transition priority per cycle, highest first:
  1. enable=0 moves any state except FAULT to OFF.
  2. Fault detection.
  3. pwm_in.
- OFF: enable=1 moves to SETTLE and loads the settle counter with EN_SETTLE.
- SETTLE: the counter decrements each cycle; at terminal count the state moves to BOT. The first conduction is always bottom, which charges the bootstrap, regardless of pwm_in.
- BOT:
  - pwm_in=1 moves to DT_TOP, loading dt_cnt=max(dt_cfg,1) and clearing to_cnt.
  - gate_status_top=1 moves to FAULT with code 11.
- DT_TOP:
  - dt_cnt decrements to 0; to_cnt increments while gate_status_bot=1.
  - Exit to TOP when dt_cnt has expired and gate_status_bot=0. Minimum time in DT_TOP is max(dt_cfg,1) cycles.
  - to_cnt reaching TO_CYC moves to FAULT with code 10.
  - pwm_in=0 while in DT_TOP returns to BOT on the next cycle; top was never commanded, so this is safe.
- TOP:
  - pwm_in=0 moves to DT_BOT with the same counter loads.
  - gate_status_bot=1 moves to FAULT with code 11.
- DT_BOT: mirror of DT_TOP.
  - Waits for gate_status_top=0; timeout gives code 01.
  - pwm_in=1 returns to TOP.
- FAULT:
  - Both fetin and enable_fetdriver are 0; fault=1 and fault_code is held.
  - enable=0 does not leave FAULT.
  - fault_clr=1 with enable=0 moves to OFF and clears fault and fault_code.
  - fault_clr with enable=1 is ignored.
- dt_cfg is sampled only at dead-time entry; changes mid-dead-time take effect on the next transition.
- Counter widths must hold EN_SETTLE and TO_CYC; counters saturate and never wrap.

Test Plan:
- Startup: rst_n=0 for 2 cycles, then enable=1, pwm_in=0 -> enable_fetdriver=1 one cycle after enable; fetin_bot=1 after 16 SETTLE cycles; fetin_top stays 0.
- Dead time: dt_cfg=5, gate status mirrors fetin with 1-cycle lag, pwm_in 0->1->0 -> exactly 5 cycles with both fetin=0 at each edge; no overlap ever.
- dt_cfg=0 -> dead time is 1 cycle. pwm_in pulse of 2 cycles during a dt_cfg=10 dead time -> returns to BOT and fetin_top is never asserted.
- Stuck gate: hold gate_status_bot=1 after BOT->DT_TOP -> FAULT after 200 cycles with fault_code=10 and all outputs low. Then enable=0, fault_clr=1 -> state OFF, fault=0.
- Shoot-through: gate_status_bot pulses high in TOP -> FAULT with code 11 next cycle. fault_clr with enable=1 -> remains in FAULT.
- Mid-operation abort: enable=0 in TOP, and separately rst_n=0 in DT_BOT -> OFF with all outputs 0 at that edge.
